// File: rtl/counter_sequencer.sv
// Programmable timer controller: latches period/prescale/mode on start and steps
// an up-counter every prescale+1 clocks, signalling done/irq at the terminal count.
module counter_sequencer #(
  parameter int WIDTH          = 4,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      irq_clear,
  output logic [WIDTH-1:0]          count,
  output logic                      busy,
  output logic                      done,
  output logic                      irq,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic                      mode_q;

  logic start_ok;
  logic start_bad;
  logic step;
  logic terminal;

  // stop always dominates a coincident start, including the error check
  assign start_ok  = start && !stop && (period != '0);
  assign start_bad = start && !stop && (period == '0);
  assign step      = (pcnt == prescale_q);
  assign terminal  = step && (count == period_q - WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      err        <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      pcnt       <= '0;
    end else begin
      done <= 1'b0;
      err  <= start_bad;
      if (irq_clear) irq <= 1'b0;

      case (state)
        IDLE: begin
          if (start_ok) begin
            period_q   <= period;
            prescale_q <= prescale;
            mode_q     <= mode;
            state      <= LOAD;
            busy       <= 1'b1;
          end
        end

        LOAD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            pcnt  <= '0;
          end else if (start_ok) begin
            period_q   <= period;
            prescale_q <= prescale;
            mode_q     <= mode;
          end else begin
            count <= '0;
            pcnt  <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (start_ok) begin
            period_q   <= period;
            prescale_q <= prescale;
            mode_q     <= mode;
            state      <= LOAD;
          end else if (step) begin
            pcnt <= '0;
            if (terminal) begin
              done <= 1'b1;
              irq  <= 1'b1;
              if (mode_q) begin
                count <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end else begin
            pcnt <= pcnt + PRESCALE_WIDTH'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed test-plan steps followed by random traffic,
// all checked against an elapsed-time reference model.
module tb_counter_sequencer;

  localparam int WIDTH = 4;
  localparam int PW    = 4;

  logic             clock = 1'b0;
  logic             reset, start, stop, mode, irq_clear;
  logic [WIDTH-1:0] period;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             busy, done, irq, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since RUN entry determines the count arithmetically
  int               m_phase;   // 0 idle, 1 loading, 2 running
  int               m_t;
  int               m_lp, m_lps;
  logic             m_lm;
  logic [WIDTH-1:0] m_count;
  logic             m_busy, m_done, m_irq, m_err;

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .prescale(prescale), .irq_clear(irq_clear),
    .count(count), .busy(busy), .done(done), .irq(irq), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit go;
    int steps, d;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (reset) begin
      m_phase = 0; m_t = 0; m_lp = 0; m_lps = 0; m_lm = 1'b0;
      m_count = '0; m_busy = 1'b0; m_irq = 1'b0;
    end else begin
      if (irq_clear) m_irq = 1'b0;
      go = start && !stop;
      if (go && period == 0) m_err = 1'b1;
      if (m_phase == 2 && stop) begin
        m_phase = 0; m_busy = 1'b0;
      end else if (m_phase == 1 && stop) begin
        m_phase = 0; m_busy = 1'b0; m_count = '0;
      end else if (go && period != 0) begin
        m_lp = int'(period); m_lps = int'(prescale); m_lm = mode;
        m_phase = 1; m_busy = 1'b1;
      end else if (m_phase == 1) begin
        m_phase = 2; m_t = 0; m_count = '0;
      end else if (m_phase == 2) begin
        m_t++;
        d = m_lps + 1;
        if (m_t % d == 0) begin
          steps = m_t / d;
          if (steps % m_lp == 0) begin
            m_done = 1'b1;
            m_irq  = 1'b1;
            if (!m_lm) begin
              m_phase = 0; m_busy = 1'b0;
              m_count = WIDTH'(m_lp - 1);
            end else begin
              m_count = '0;
            end
          end else begin
            m_count = WIDTH'(steps % m_lp);
          end
        end
      end
    end
  endtask

  // one clock: update the model at the edge, then compare all outputs after it
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    chk("count", int'(count), int'(m_count));
    chk("busy",  int'(busy),  int'(m_busy));
    chk("done",  int'(done),  int'(m_done));
    chk("irq",   int'(irq),   int'(m_irq));
    chk("err",   int'(err),   int'(m_err));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0; irq_clear = 1'b0;
    period = 4'd5; prescale = '0;
    m_phase = 0; m_t = 0; m_lp = 0; m_lps = 0; m_lm = 1'b0;
    m_count = '0; m_busy = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_err = 1'b0;

    // 1: reset dominates a held start
    cycles(2);
    chk("rst_count", int'(count), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_irq",   int'(irq), 0);
    reset = 1'b0; start = 1'b0;

    // 2: periodic, period 5, prescale 0
    period = 4'd5; prescale = 4'd0; mode = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("p5_busy_N", int'(busy), 1);
    cycle();
    chk("p5_cnt_N1", int'(count), 0);
    cycles(4);
    chk("p5_cnt_N5", int'(count), 4);
    cycle();
    chk("p5_wrap_cnt", int'(count), 0);
    chk("p5_wrap_done", int'(done), 1);
    chk("p5_irq", int'(irq), 1);
    cycles(4);
    cycle();
    chk("p5_done_rep", int'(done), 1);

    // 3: one-shot, period 3, prescale 2 (restart from RUN)
    period = 4'd3; prescale = 4'd2; mode = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(4);
    chk("os_cnt_N4", int'(count), 1);
    cycles(3);
    chk("os_cnt_N7", int'(count), 2);
    cycles(3);
    chk("os_done", int'(done), 1);
    chk("os_busy", int'(busy), 0);
    chk("os_hold", int'(count), 2);
    cycles(3);
    chk("os_hold2", int'(count), 2);
    irq_clear = 1'b1;
    cycle();
    irq_clear = 1'b0;
    chk("os_irq_clr", int'(irq), 0);

    // 4: start with period 0
    period = 4'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_cnt", int'(count), 2);
    cycle();
    chk("err_once", int'(err), 0);

    // 5: stop while running, then start+stop, then start alone
    period = 4'd8; prescale = 4'd0; mode = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(4);
    chk("stop_pre", int'(count), 3);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_cnt", int'(count), 3);
    chk("stop_done", int'(done), 0);
    start = 1'b1; stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    cycle();
    start = 1'b0;
    cycle();
    chk("restart_cnt", int'(count), 0);
    chk("restart_busy", int'(busy), 1);

    // 6: set wins over irq_clear; reset mid-run
    period = 4'd4; prescale = 4'd0; mode = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(5);
    chk("p4_irq_set", int'(irq), 1);
    cycles(2);
    irq_clear = 1'b1;
    cycles(2);
    chk("p4_set_wins_done", int'(done), 1);
    chk("p4_set_wins_irq", int'(irq), 1);
    irq_clear = 1'b0;
    cycles(2);
    chk("p4_cnt2", int'(count), 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_cnt", int'(count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_irq", int'(irq), 0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 31) == 0);
      irq_clear = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      mode      = 1'($urandom_range(0, 1));
      period    = WIDTH'($urandom_range(0, 15));
      prescale  = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 15))
                                               : PW'($urandom_range(0, 2));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
